// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared depth default and sweep FSM state encoding for the data RAM
package data_ram_pkg;
    localparam int DATA_MEM_NUM_LOG2 = 10;
    typedef enum logic {RAM_INIT, RAM_RUN} ram_state_t;
endpackage

// File: rtl/data_ram_lane.sv
// data_ram_lane: one 8-bit x 2**ADDR_W byte lane, synchronous write, asynchronous read
// Ports: clk clock; we write enable; waddr/wdata write port; raddr/rdata combinational read port
module data_ram_lane #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/data_ram.sv
// data_ram: CPU data memory with big-endian byte-lane stores, async word loads, zero-fill sweep, error flag and counters
// Ports: clk clock; rst async active-low reset; ce/we/addr/sel/data_i CPU access; data_o load data;
//        init_busy_o high in reset and during sweep; err_o sticky access error; rd_cnt_o/wr_cnt_o access counters
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = DATA_MEM_NUM_LOG2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [3:0]       sel,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    output logic             init_busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o
);
    ram_state_t        state, next;
    logic [ADDR_W-1:0] ptr, idx;
    logic [31:0]       rdata;
    logic              sweep, run, in_range, load_ok, store_ok, bad;
    logic              unused_ok;

    assign unused_ok = &{1'b0, addr[1:0]};
    assign idx       = addr[ADDR_W+1:2];
    assign in_range  = addr[31:ADDR_W+2] == '0;
    assign sweep     = state == RAM_INIT;
    assign run       = state == RAM_RUN;
    assign load_ok   = run & ce & ~we & in_range;
    assign store_ok  = run & ce & we & in_range & (|sel);
    // Any RUN access that is neither an accepted load nor an accepted store is an error
    assign bad       = run & ce & ~load_ok & ~store_ok;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= RAM_INIT;
            ptr      <= '0;
            err_o    <= 1'b0;
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            state <= next;
            if (sweep) ptr <= ptr + ADDR_W'(1);
            if (bad) err_o <= 1'b1;
            if (load_ok) rd_cnt_o <= rd_cnt_o + CNT_W'(1);
            if (store_ok) wr_cnt_o <= wr_cnt_o + CNT_W'(1);
        end

    // Last sweep write lands on the all-ones pointer, then RUN holds until reset
    always_comb begin
        next = state;
        if (sweep && &ptr) next = RAM_RUN;
    end

    // sel[k] gates data bits [8k+7:8k], so sel[3] is the big-endian byte 0
    for (genvar k = 0; k < 4; k++) begin : g_lane
        data_ram_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk   (clk),
            .we    (sweep | (store_ok & sel[k])),
            .waddr (sweep ? ptr : idx),
            .wdata (sweep ? 8'h00 : data_i[8*k +: 8]),
            .raddr (idx),
            .rdata (rdata[8*k +: 8])
        );
    end

    assign data_o      = load_ok ? rdata : 32'h0;
    assign init_busy_o = sweep;
endmodule
